// File: rtl/wb_stage_if.sv
// MEM/WB boundary bundle: memory-stage results in, decode read ports and hazard taps out.
interface wb_stage_if #(
  parameter int unsigned REG_ADDR_W = 6
);
  logic                  StallW;
  logic                  FlushW;
  logic                  MemtoRegW;
  logic                  RegWriteW;
  logic                  HI_LO_write_enableW;
  logic [31:0]           Hi_LO_dataW;
  logic [31:0]           RAMout;
  logic [31:0]           ALUoutW;
  logic [REG_ADDR_W-1:0] WriteRegisterW;
  logic [4:0]            RsAddr;
  logic [4:0]            RtAddr;
  logic                  HiLoSel;
  logic [31:0]           RsData;
  logic [31:0]           RtData;
  logic [31:0]           HiLoData;
  logic [31:0]           ResultW;
  logic [REG_ADDR_W-1:0] WriteRegOutW;
  logic                  RegWriteOutW;

  // Upstream/decode side: drives stage inputs and read addresses.
  modport master (
    output StallW, FlushW, MemtoRegW, RegWriteW, HI_LO_write_enableW, Hi_LO_dataW,
           RAMout, ALUoutW, WriteRegisterW, RsAddr, RtAddr, HiLoSel,
    input  RsData, RtData, HiLoData, ResultW, WriteRegOutW, RegWriteOutW
  );

  // Writeback stage side.
  modport slave (
    input  StallW, FlushW, MemtoRegW, RegWriteW, HI_LO_write_enableW, Hi_LO_dataW,
           RAMout, ALUoutW, WriteRegisterW, RsAddr, RtAddr, HiLoSel,
    output RsData, RtData, HiLoData, ResultW, WriteRegOutW, RegWriteOutW
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result select, GPR file plus HI/LO,
// and decode read ports with write-before-read bypass.
module wb_stage #(
  parameter int unsigned REG_ADDR_W      = 6,
  parameter int unsigned RESET_PC_UNUSED = 0
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus_io
);

  localparam logic [REG_ADDR_W-1:0] DestHi = REG_ADDR_W'(32);
  localparam logic [REG_ADDR_W-1:0] DestLo = REG_ADDR_W'(33);

  // Reserved for parameter-list compatibility with sibling stages; no hardware.
  if (RESET_PC_UNUSED != 0) begin : g_reserved_param
  end

  typedef struct packed {
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  hilo_we;
    logic [31:0]           hilo_data;
    logic [31:0]           ram_out;
    logic [31:0]           alu_out;
    logic [REG_ADDR_W-1:0] dest;
  } stage_t;

  stage_t      stage_d, stage_q;
  logic [31:0] gpr_q [32];
  logic [31:0] hi_q, lo_q;
  logic [31:0] result;
  logic        gpr_we, hi_we, lo_we;
  logic [31:0] rs_data, rt_data, hilo_data;

  // Next MEM/WB contents: flush beats stall, stall holds, otherwise capture.
  always_comb begin
    stage_d = stage_q;
    if (bus_io.FlushW) begin
      stage_d = '0;
    end else if (!bus_io.StallW) begin
      stage_d.mem_to_reg = bus_io.MemtoRegW;
      stage_d.reg_write  = bus_io.RegWriteW;
      stage_d.hilo_we    = bus_io.HI_LO_write_enableW;
      stage_d.hilo_data  = bus_io.Hi_LO_dataW;
      stage_d.ram_out    = bus_io.RAMout;
      stage_d.alu_out    = bus_io.ALUoutW;
      stage_d.dest       = bus_io.WriteRegisterW;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Result select and effective write enables; codes 34 and up target nothing.
  always_comb begin
    result = stage_q.mem_to_reg ? stage_q.ram_out : stage_q.alu_out;
    gpr_we = stage_q.reg_write && (stage_q.dest < DestHi) && (stage_q.dest[4:0] != 5'd0);
    hi_we  = stage_q.hilo_we && (stage_q.dest == DestHi);
    lo_we  = stage_q.hilo_we && (stage_q.dest == DestLo);
  end

  // Architectural state; a stalled entry keeps rewriting the same value, which is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (gpr_we) begin
        gpr_q[stage_q.dest[4:0]] <= result;
      end
      if (hi_we) begin
        hi_q <= stage_q.hilo_data;
      end
      if (lo_we) begin
        lo_q <= stage_q.hilo_data;
      end
    end
  end

  // Read ports: $zero forced to 0, pending writeback bypasses the file.
  always_comb begin
    rs_data = gpr_q[bus_io.RsAddr];
    if (gpr_we && (bus_io.RsAddr == stage_q.dest[4:0])) begin
      rs_data = result;
    end
    if (bus_io.RsAddr == 5'd0) begin
      rs_data = '0;
    end
    rt_data = gpr_q[bus_io.RtAddr];
    if (gpr_we && (bus_io.RtAddr == stage_q.dest[4:0])) begin
      rt_data = result;
    end
    if (bus_io.RtAddr == 5'd0) begin
      rt_data = '0;
    end
    if (!bus_io.HiLoSel) begin
      hilo_data = hi_we ? stage_q.hilo_data : hi_q;
    end else begin
      hilo_data = lo_we ? stage_q.hilo_data : lo_q;
    end
  end

  assign bus_io.RsData       = rs_data;
  assign bus_io.RtData       = rt_data;
  assign bus_io.HiLoData     = hilo_data;
  assign bus_io.ResultW      = result;
  assign bus_io.WriteRegOutW = stage_q.dest;
  assign bus_io.RegWriteOutW = gpr_we;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed plan steps followed by random traffic against a
// behavioural model of the register file, HI/LO and the stage register.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.REG_ADDR_W(6)) bus ();

  wb_stage #(.REG_ADDR_W(6), .RESET_PC_UNUSED(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct packed {
    logic        m2r;
    logic        rw;
    logic        hw;
    logic [31:0] hd;
    logic [31:0] ram;
    logic [31:0] alu;
    logic [5:0]  dst;
  } mstage_t;

  mstage_t     st;
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  int          n_vec  = 0;
  int          n_fail = 0;

  function automatic logic [31:0] m_result();
    return st.m2r ? st.ram : st.alu;
  endfunction

  function automatic logic m_gpr_en();
    return st.rw && (st.dst >= 6'd1) && (st.dst <= 6'd31);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (m_gpr_en() && (a == st.dst[4:0])) return m_result();
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] m_hilo(input logic sel);
    logic [5:0] want;
    want = sel ? 6'd33 : 6'd32;
    if (st.hw && (st.dst == want)) return st.hd;
    return sel ? m_lo : m_hi;
  endfunction

  task automatic m_reset();
    st = '0;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
  endtask

  // Model the effect of one rising edge, then let the DUT take it.
  task automatic step();
    if (rst) begin
      m_reset();
    end else begin
      if (m_gpr_en()) m_gpr[st.dst[4:0]] = m_result();
      if (st.hw && st.dst == 6'd32) m_hi = st.hd;
      if (st.hw && st.dst == 6'd33) m_lo = st.hd;
      if (bus.FlushW) begin
        st = '0;
      end else if (!bus.StallW) begin
        st = '{m2r: bus.MemtoRegW, rw: bus.RegWriteW, hw: bus.HI_LO_write_enableW,
               hd: bus.Hi_LO_dataW, ram: bus.RAMout, alu: bus.ALUoutW, dst: bus.WriteRegisterW};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                             input logic sel);
    bus.RsAddr  = rs;
    bus.RtAddr  = rt;
    bus.HiLoSel = sel;
    #1;
    chk({tag, ".rs"},     bus.RsData,               m_read(rs));
    chk({tag, ".rt"},     bus.RtData,               m_read(rt));
    chk({tag, ".hilo"},   bus.HiLoData,             m_hilo(sel));
    chk({tag, ".result"}, bus.ResultW,              m_result());
    chk({tag, ".wreg"},   32'(bus.WriteRegOutW),    32'(st.dst));
    chk({tag, ".wen"},    32'(bus.RegWriteOutW),    32'(m_gpr_en()));
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic hw, input logic [5:0] dst,
                       input logic [31:0] alu, input logic [31:0] ram, input logic [31:0] hd);
    bus.RegWriteW           = rw;
    bus.MemtoRegW           = m2r;
    bus.HI_LO_write_enableW = hw;
    bus.WriteRegisterW      = dst;
    bus.ALUoutW             = alu;
    bus.RAMout              = ram;
    bus.Hi_LO_dataW         = hd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    m_reset();
    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;
    idle();
    bus.RsAddr  = 5'd5;
    bus.RtAddr  = 5'd31;
    bus.HiLoSel = 1'b0;

    // Reset then read.
    #12;
    check_reads("rst_hi", 5'd5, 5'd31, 1'b0);
    check_reads("rst_lo", 5'd5, 5'd31, 1'b1);
    chk("rst_rs_const", bus.RsData, 32'h0);
    rst = 1'b0;
    step();
    check_reads("post_rst", 5'd5, 5'd31, 1'b1);

    // ALU writeback with bypass, then from the file.
    drive(1'b1, 1'b0, 1'b0, 6'd9, 32'h1234_5678, 32'h0, 32'h0);
    step();
    idle();
    check_reads("alu_bypass", 5'd9, 5'd1, 1'b0);
    chk("alu_result_const", bus.ResultW, 32'h1234_5678);
    chk("alu_wen_const", 32'(bus.RegWriteOutW), 32'd1);
    step();
    check_reads("alu_file", 5'd9, 5'd9, 1'b0);
    chk("alu_file_const", bus.RsData, 32'h1234_5678);

    // Load writeback held by stall, then flushed.
    drive(1'b1, 1'b1, 1'b0, 6'd3, 32'h0BAD_0BAD, 32'hFFFF_FF80, 32'h0);
    step();
    bus.StallW = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 6'd4, 32'h1111_2222, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step();
    check_reads("load_stall", 5'd3, 5'd4, 1'b0);
    chk("load_stall_const", bus.RtData, 32'h0);
    bus.FlushW = 1'b1;
    step();
    bus.FlushW = 1'b0;
    bus.StallW = 1'b0;
    check_reads("load_flush", 5'd3, 5'd4, 1'b0);
    chk("flush_wen_const", 32'(bus.RegWriteOutW), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 6'd5, 32'h7777_7777, 32'h0, 32'h0);
    step();
    idle();
    step();
    check_reads("gpr3_kept", 5'd3, 5'd5, 1'b0);
    chk("gpr3_const", bus.RsData, 32'hFFFF_FF80);

    // $zero protection.
    drive(1'b1, 1'b0, 1'b0, 6'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    step();
    idle();
    check_reads("zero_pend", 5'd0, 5'd0, 1'b0);
    step();
    check_reads("zero_after", 5'd0, 5'd9, 1'b0);

    // HI then LO, then a no-target code with both enables.
    drive(1'b0, 1'b0, 1'b1, 6'd32, 32'h0, 32'h0, 32'hAAAA_0001);
    step();
    drive(1'b0, 1'b0, 1'b1, 6'd33, 32'h0, 32'h0, 32'h5555_0002);
    step();
    idle();
    check_reads("lo_pend", 5'd9, 5'd3, 1'b1);
    step();
    check_reads("hi_rd", 5'd9, 5'd3, 1'b0);
    chk("hi_const", bus.HiLoData, 32'hAAAA_0001);
    check_reads("lo_rd", 5'd9, 5'd3, 1'b1);
    chk("lo_const", bus.HiLoData, 32'h5555_0002);
    drive(1'b1, 1'b0, 1'b1, 6'd40, 32'h1212_1212, 32'h0, 32'h3434_3434);
    step();
    idle();
    step();
    check_reads("nt_hi", 5'd8, 5'd9, 1'b0);
    check_reads("nt_lo", 5'd8, 5'd0, 1'b1);

    // Asynchronous reset while a write to GPR7 is pending.
    drive(1'b1, 1'b0, 1'b0, 6'd7, 32'h0000_00FF, 32'h0, 32'h0);
    step();
    idle();
    check_reads("pend7", 5'd7, 5'd9, 1'b0);
    #2;
    rst = 1'b1;
    m_reset();
    check_reads("async_rst", 5'd7, 5'd9, 1'b0);
    chk("async_rst_const", bus.RsData, 32'h0);
    rst = 1'b0;
    step();
    check_reads("post_async", 5'd7, 5'd3, 1'b0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      logic [5:0] d;
      int         k;
      k = int'($urandom_range(0, 9));
      if (k < 6)       d = 6'($urandom_range(0, 7));
      else if (k == 6) d = 6'd32;
      else if (k == 7) d = 6'd33;
      else if (k == 8) d = 6'($urandom_range(34, 63));
      else             d = 6'($urandom_range(0, 31));
      drive(1'($urandom), 1'($urandom), 1'($urandom), d, $urandom, $urandom, $urandom);
      bus.StallW = ($urandom_range(0, 4) == 0);
      bus.FlushW = ($urandom_range(0, 9) == 0);
      step();
      check_reads("rand", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'($urandom));
    end

    // Drain the stage, then sweep the whole file.
    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;
    idle();
    step();
    step();
    for (int a = 0; a < 32; a++) begin
      check_reads("sweep", 5'(a), 5'(31 - a), 1'(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage MIPS pipeline, directly downstream of the memory stage.
- Latches the memory stage's outputs into the MEM/WB pipeline register.
- Selects the writeback result (load data or ALU result) and owns the architectural state: 32x32 GPR file plus HI and LO.
- Provides two GPR read ports and a HI/LO read port to decode, with write-before-read bypass.

Parameters:
- REG_ADDR_W, 6, width of the destination-register code. Codes 0-31 are GPRs, 32 is HI, 33 is LO, 34-63 are no-target.
- RESET_PC_UNUSED, 0, reserved; no effect. Kept for parameter-list stability with sibling stages.

Ports:
- clk  input  1  stage clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- StallW  input  1  hold MEM/WB register contents
- FlushW  input  1  load a bubble into MEM/WB register
- MemtoRegW  input  1  from memory stage: result is load data
- RegWriteW  input  1  from memory stage: GPR write request
- HI_LO_write_enableW  input  1  from memory stage: HI/LO write request
- Hi_LO_dataW  input  32  from memory stage: HI/LO write data
- RAMout  input  32  from memory stage: aligned, extended load data
- ALUoutW  input  32  from memory stage: ALU result
- WriteRegisterW  input  6  from memory stage: destination code
- RsAddr  input  5  decode read port A address
- RtAddr  input  5  decode read port B address
- HiLoSel  input  1  0 reads HI, 1 reads LO
- RsData  output  32  read port A data
- RtData  output  32  read port B data
- HiLoData  output  32  HI or LO read data
- ResultW  output  32  registered-stage writeback value, for forwarding
- WriteRegOutW  output  6  registered destination code, for hazard unit
- RegWriteOutW  output  1  registered effective GPR write enable, for hazard unit

Behaviour:
- Reset (rst=1, asynchronous): all 32 GPRs, HI, LO and every MEM/WB register field clear to 0. With all fields at 0, ResultW=0, WriteRegOutW=0 and RegWriteOutW=0. Read outputs show 0 while reset is held.
- MEM/WB register, on rising clk edge with rst=0:
  - FlushW=1: RegWrite and HI_LO_write_enable fields clear to 0; other fields are don't-care, implemented as clear.
  - FlushW=0 and StallW=1: hold all fields.
  - Otherwise: capture all seven memory-stage inputs.
  - FlushW has priority over StallW.
- Result select, combinational from the register: ResultW = RAMout field if MemtoReg field=1, else ALUout field.
- Effective GPR write enable: RegWriteOutW = RegWrite field AND destination<32 AND destination!=0.
- Effective HI/LO write enable: HI_LO_write_enable field AND destination in {32,33}.
- Architectural update, one edge after capture (total latency 2 edges from memory-stage output to visible state):
  - GPR[dest[4:0]] <= ResultW when the effective GPR enable is 1.
  - HI <= Hi_LO data field when dest=32 and HI/LO is enabled.
  - LO <= Hi_LO data field when dest=33 and HI/LO is enabled.
  - Architectural writes happen even when StallW=1. The held entry rewrites the same value every cycle, which is idempotent.
- GPR[0] reads as 0 and is never written.
- Destination codes 34-63 with any enable write nothing.
- RsData / RtData, combinational:
  - address 0 returns 0;
  - else if the effective GPR enable is 1 and the address equals dest[4:0], return ResultW (bypass);
  - else return the GPR file.
- HiLoData: returns the Hi_LO data field if a HI/LO write to the selected register is pending in the stage register; else returns the stored HI or LO.
- Simultaneous RegWrite and HI_LO_write_enable: each applies only under its own destination rule, so at most one takes effect.
- Reset asserted mid-operation: state clears immediately and any pending write is discarded.

Test Plan:
- Reset then read: assert rst, read Rs=5, Rt=31, HiLoSel=0/1 -> all outputs 0. Release rst -> still 0.
- ALU writeback: RegWriteW=1, MemtoRegW=0, ALUoutW=32'h1234_5678, WriteRegisterW=6'd9, one cycle -> ResultW=32'h12345678, RegWriteOutW=1. RsAddr=9 returns 32'h12345678 during bypass and after the next edge.
- Load writeback with stall and flush: RAMout=32'hFFFF_FF80, MemtoRegW=1, dest=6'd3, StallW=1 for 3 cycles -> register holds and GPR3=32'hFFFFFF80. Then FlushW=1 together with StallW=1 -> RegWriteOutW=0 next cycle and GPR3 is unchanged by later inputs.
- $zero protection: RegWriteW=1, dest=6'd0, ALUoutW=32'hDEAD_BEEF -> RegWriteOutW=0 and RsAddr=0 returns 0.
- HI/LO writes: HI_LO_write_enableW=1, dest=6'd32, data=32'hAAAA_0001; next cycle dest=6'd33, data=32'h5555_0002 -> HiLoData=32'hAAAA0001 for HiLoSel=0 and 32'h55550002 for HiLoSel=1. No GPR changes; dest=6'd40 writes nothing.
- Async reset mid-write: a pending write of 32'h0000_00FF to GPR7 with rst asserted between edges -> GPR7 reads 0 immediately and stays 0 after release.
